// File: rtl/sipo_deserializer.sv
// ----------------------------------------------------------------------------
// sipo_deserializer
//  Receive end of the serial shift-register link. Serial bits sampled on
//  shift_en are assembled into WIDTH-bit words, framed by an internal bit
//  counter. Each completed word is presented on a valid/ready output register.
//  A word that completes while an unconsumed word is still held is dropped and
//  raises a sticky overrun flag.
//
// Ports
//  clk           rising-edge clock
//  rst_n         asynchronous active-low reset
//  clr           synchronous clear of frame, output and overrun state
//  shift_en      serial_in is valid this cycle
//  serial_in     serial data bit
//  parallel_out  last completed word (held while out_valid=1)
//  out_valid     parallel_out holds an unconsumed word
//  out_ready     consumer accepts the word when out_valid & out_ready
//  busy          a frame is partially received (bit_cnt != 0)
//  bit_cnt       bits of the current frame received so far
//  overrun       sticky: a completed word was dropped
// ----------------------------------------------------------------------------
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun
);

    typedef enum logic {StIdle, StCollect} state_e;

    state_e             r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   r_pout;
    logic               r_valid;
    logic [CW-1:0]      r_cnt;
    logic               r_over;

    logic [WIDTH-1:0]   w_sreg_next;
    logic               w_complete;
    logic               w_unused_drop;

    // The shift pushes one bit off the far end; it is never needed because a
    // word is captured from w_sreg_next on the edge its last bit arrives.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sreg_next   = {r_sreg[WIDTH-2:0], serial_in};
            assign w_unused_drop = r_sreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_sreg_next   = {serial_in, r_sreg[WIDTH-1:1]};
            assign w_unused_drop = r_sreg[0];
        end
    endgenerate

    assign w_complete = shift_en && (r_state == StCollect) && (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_sreg  <= '0;
            r_pout  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_over  <= 1'b0;
        end else if (clr) begin
            r_state <= StIdle;
            r_sreg  <= '0;
            r_pout  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_over  <= 1'b0;
        end else begin
            // Frame assembly
            unique case (r_state)
                StIdle: begin
                    if (shift_en) begin
                        r_sreg  <= w_sreg_next;
                        r_cnt   <= CW'(1);
                        r_state <= StCollect;
                    end
                end
                StCollect: begin
                    if (shift_en) begin
                        r_sreg <= w_sreg_next;
                        if (w_complete) begin
                            r_cnt   <= '0;
                            r_state <= StIdle;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
            endcase

            // Output register: a completing word may replace the held word only
            // if that held word is being consumed on this same edge.
            if (w_complete) begin
                if (!r_valid || out_ready) begin
                    r_pout  <= w_sreg_next;
                    r_valid <= 1'b1;
                end else begin
                    r_over <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign parallel_out = r_pout;
    assign out_valid    = r_valid;
    assign busy         = (r_state == StCollect);
    assign bit_cnt      = r_cnt;
    assign overrun      = r_over;

endmodule
